// File: rtl/score_bcd_converter.sv
// score_bcd_converter: sequential binary-to-BCD converter (shift-add-3),
// one shift per clock, producing four decimal digits for a 4-digit display.
// Values above MAX_VAL are shown as dashes (4'hF per digit) with ovf set.
// The displayed digits and ovf only change when a conversion finishes, so
// the display never shows a partially converted value.
module score_bcd_converter #(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] bin,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       dig0,
  output logic [3:0]       dig1,
  output logic [3:0]       dig2,
  output logic [3:0]       dig3
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  state_t           state_q, state_d;
  logic [BIN_W-1:0] sr_q, sr_d;         // binary value being shifted out
  logic [15:0]      acc_q, acc_d;       // BCD accumulator, four nibbles
  logic [15:0]      acc_adj;            // accumulator after the add-3 step
  logic [3:0]       cnt_q, cnt_d;       // shifts performed so far
  logic             ovf_pend_q, ovf_pend_d;
  logic [15:0]      dig_q, dig_d;       // displayed digits {dig3..dig0}
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // Add 3 to every nibble that is 5 or more, so the following shift
  // carries correctly into the next decimal digit.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state and datapath control for the IDLE/SHIFT/LOAD sequencer.
  // NOTE: every variable gets a default first so no path leaves one
  // unassigned; a missing default in always_comb infers a latch.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    dig_d      = dig_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d       = bin;
          acc_d      = '0;
          cnt_d      = '0;
          // Widen both sides so the range check cannot wrap.
          ovf_pend_d = (32'(bin) > 32'(MAX_VAL));
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        // Adjusted accumulator and shift register move left as one word.
        acc_d = (acc_adj << 1) | 16'(sr_q[BIN_W-1]);
        sr_d  = sr_q << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(BIN_W - 1)) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        dig_d   = ovf_pend_q ? 16'hFFFF : acc_q;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its old-cycle inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      dig_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      dig_q      <= dig_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign ovf  = ovf_q;
  assign dig0 = dig_q[3:0];
  assign dig1 = dig_q[7:4];
  assign dig2 = dig_q[11:8];
  assign dig3 = dig_q[15:12];

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed testbench for score_bcd_converter. Inputs are driven and outputs
// sampled on the falling clock edge; expected digits come from an
// arithmetic (divide/modulo) reference model.
module tb_score_bcd_converter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] bin = '0;
  logic        start = 1'b0;
  logic        busy, done, ovf;
  logic [3:0]  dig0, dig1, dig2, dig3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  score_bcd_converter #(.BIN_W(14), .MAX_VAL(9999)) dut (
    .clk  (clk),
    .reset(reset),
    .bin  (bin),
    .start(start),
    .busy (busy),
    .done (done),
    .ovf  (ovf),
    .dig0 (dig0),
    .dig1 (dig1),
    .dig2 (dig2),
    .dig3 (dig3)
  );

  function automatic logic [15:0] ref_digits(input int v);
    if (v > 9999) return 16'hFFFF;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] shown();
    return {dig3, dig2, dig1, dig0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One conversion: call on a falling edge. Checks latency 16, busy for
  // 15 cycles, outputs held until the result, result, ovf and single done.
  task automatic run_conv(input int v, input string tag);
    logic [15:0] prev_d;
    logic        prev_o;
    int          lat, busy_n;
    bit          held;
    prev_d = shown();
    prev_o = ovf;
    bin    = 14'(v);
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    bin    = ~14'(v);          // later bin changes must not matter
    lat    = 0;
    busy_n = 0;
    held   = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busy_n++;
      if (shown() !== prev_d || ovf !== prev_o) held = 1'b0;
    end
    check({tag, "_latency"}, lat, 16);
    check({tag, "_busy_cycles"}, busy_n, 15);
    check({tag, "_held"}, held, 1);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_digits"}, shown(), ref_digits(v));
    check({tag, "_ovf"}, ovf, (v > 9999) ? 1 : 0);
    @(negedge clk);
    check({tag, "_done_single"}, done, 0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_digits", shown(), 16'h0000);
    reset = 1'b0;

    // Basic conversion, first start right after reset release.
    run_conv(1234, "c1234");
    check("c1234_exact", shown(), 16'h1234);

    // Back-to-back extremes.
    run_conv(0, "c0");
    check("c0_exact", shown(), 16'h0000);
    run_conv(9999, "c9999");
    check("c9999_exact", shown(), 16'h9999);

    // Overflow, then a normal value clears ovf.
    run_conv(10000, "c10000");
    check("c10000_exact", shown(), 16'hFFFF);
    run_conv(16383, "c16383");
    check("c16383_ovf", ovf, 1);
    run_conv(42, "c42");
    check("c42_exact", shown(), 16'h0042);
    check("c42_ovf", ovf, 0);

    // Start held high while bin changes every cycle: accepted every 16.
    start = 1'b1;
    for (int c = 0; c < 48; c++) begin
      bin = 14'(100 * c + 7);
      @(posedge clk);
      @(negedge clk);
      if (c % 16 == 15) begin
        check($sformatf("hold_done%0d", c), done, 1);
        check($sformatf("hold_dig%0d", c), shown(),
              ref_digits(100 * (c - 15) + 7));
      end else begin
        check($sformatf("hold_nodone%0d", c), done, 0);
      end
    end
    start = 1'b0;

    // Reset in the middle of a conversion aborts it.
    bin   = 14'd5678;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ovf", ovf, 0);
    check("abort_digits", shown(), 16'h0000);
    run_conv(5678, "c5678");
    check("c5678_exact", shown(), 16'h5678);

    // Sweep against the reference model: dense low range, strided middle,
    // dense windows at the overflow threshold and the top of the range.
    for (int v = 0; v < 1024; v++) run_conv(v, $sformatf("sw%0d", v));
    for (int v = 1024; v < 16384; v += 37) run_conv(v, $sformatf("sw%0d", v));
    for (int v = 9990; v <= 10010; v++) run_conv(v, $sformatf("sw%0d", v));
    for (int v = 16370; v < 16384; v++) run_conv(v, $sformatf("sw%0d", v));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
